temp_display: RTL and testbench

//  Downstream consumer of the I2C temperature reader. Captures data[7:0] on each rising edge of update:
//  [7:3] = integer degrees, 0..31; [2:0] = eighths of a degree.

---
 rtl/temp_display_pkg.sv | 58 +++++
 rtl/temp_display_bin2bcd.sv | 53 +++++
 rtl/temp_display.sv | 204 ++++++++++++++++++++
 tb/tb_temp_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_display_pkg.sv
// Shared constants and helpers for the temperature display: FSM state codes,
// capture-source selects, segment patterns and digit encoders.
package temp_display_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  localparam logic [1:0] CAP_HOLD = 2'd0;
  localparam logic [1:0] CAP_DATA = 2'd1;
  localparam logic [1:0] CAP_PEND = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] seg7_hex(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Eighths of a degree to a truncated tenths digit
  function automatic logic [3:0] tenths_lut(input logic [2:0] frac);
    logic [3:0] t;
    case (frac)
      3'd0:    t = 4'd0;
      3'd1:    t = 4'd1;
      3'd2:    t = 4'd2;
      3'd3:    t = 4'd3;
      3'd4:    t = 4'd5;
      3'd5:    t = 4'd6;
      3'd6:    t = 4'd7;
      3'd7:    t = 4'd8;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/temp_display_bin2bcd.sv
// bin2bcd_seq: 5-bit binary to two BCD digits by sequential double-dabble.
// A start pulse loads the operand and clears the BCD register; five shift cycles follow.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [4:0] bin_r;
  logic [7:0] bcd_r;
  logic [2:0] cnt_r;
  logic [7:0] adj_s;

  // Add-3 correction of each nibble ahead of the shift
  always_comb begin
    adj_s = bcd_r;
    if (bcd_r[3:0] >= 4'd5) adj_s[3:0] = bcd_r[3:0] + 4'd3;
    else                    adj_s[3:0] = bcd_r[3:0];
    if (bcd_r[7:4] >= 4'd5) adj_s[7:4] = bcd_r[7:4] + 4'd3;
    else                    adj_s[7:4] = bcd_r[7:4];
  end

  // Operand load and MSB-first shift sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r <= 5'd0;
      bcd_r <= 8'd0;
      cnt_r <= 3'd0;
    end else if (start) begin
      bin_r <= bin;
      bcd_r <= 8'd0;
      cnt_r <= 3'd5;
    end else if (cnt_r != 3'd0) begin
      bcd_r <= {adj_s[6:0], bin_r[4]};
      bin_r <= {bin_r[3:0], 1'b0};
      cnt_r <= cnt_r - 3'd1;
    end else begin
      bin_r <= bin_r;
      bcd_r <= bcd_r;
      cnt_r <= cnt_r;
    end
  end

  // High during the final shift cycle, so the result is stable on the next cycle
  assign done  = (cnt_r == 3'd1);
  assign tens  = bcd_r[7:4];
  assign units = bcd_r[3:0];

endmodule

// File: rtl/temp_display.sv
// temp_display: captures temperature samples on update rising edges, converts the
// integer part to BCD and scans a multiplexed active-low 4-digit display as " TU.t".
module temp_display
  import temp_display_pkg::*;
#(
  parameter int SCAN_DIV      = 25000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       update,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       valid,
  output logic       busy
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [1:0]        state_r, state_nxt_s;
  logic              update_q_r, edge_s;
  logic [4:0]        cap_int_r;
  logic [2:0]        cap_frac_r;
  logic [7:0]        pend_data_r;
  logic              pend_r, start_r, busy_r, valid_r;
  logic [1:0]        cap_sel_s;
  logic              start_s, pend_wr_s, pend_clr_s, load_shown_s, busy_nxt_s;
  logic              conv_done_s;
  logic [3:0]        bcd_tens_s, bcd_units_s;
  logic [7:0]        tens_seg_s, units_seg_s, tenths_seg_s;
  logic [7:0]        shown_tens_r, shown_units_r, shown_tenths_r;
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        dig_idx_r;
  logic [7:0]        slot_seg_s, seg_r;
  logic [3:0]        slot_dig_s, dig_r;

  assign edge_s = update & ~update_q_r;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_r),
    .bin   (cap_int_r),
    .done  (conv_done_s),
    .tens  (bcd_tens_s),
    .units (bcd_units_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (edge_s) state_nxt_s = ST_CONVERT; else state_nxt_s = ST_IDLE;
      ST_CONVERT: if (conv_done_s) state_nxt_s = ST_LOAD; else state_nxt_s = ST_CONVERT;
      ST_LOAD:    if (edge_s || pend_r) state_nxt_s = ST_CONVERT; else state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM controls; an edge seen in LOAD is newer than any pending sample
  always_comb begin
    cap_sel_s    = CAP_HOLD;
    start_s      = 1'b0;
    pend_wr_s    = 1'b0;
    pend_clr_s   = 1'b0;
    load_shown_s = 1'b0;
    busy_nxt_s   = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          cap_sel_s  = CAP_DATA;
          start_s    = 1'b1;
          busy_nxt_s = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_CONVERT: begin
        busy_nxt_s = 1'b1;
        if (edge_s) pend_wr_s = 1'b1;
        else        pend_wr_s = 1'b0;
      end
      ST_LOAD: begin
        load_shown_s = 1'b1;
        if (edge_s) begin
          cap_sel_s  = CAP_DATA;
          start_s    = 1'b1;
          pend_clr_s = 1'b1;
          busy_nxt_s = 1'b1;
        end else if (pend_r) begin
          cap_sel_s  = CAP_PEND;
          start_s    = 1'b1;
          pend_clr_s = 1'b1;
          busy_nxt_s = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Edge detect, sample capture, pending buffer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_q_r  <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      cap_int_r   <= 5'd0;
      cap_frac_r  <= 3'd0;
      pend_data_r <= 8'd0;
      pend_r      <= 1'b0;
    end else begin
      update_q_r <= update;
      start_r    <= start_s;
      busy_r     <= busy_nxt_s;
      if (load_shown_s) valid_r <= 1'b1;
      case (cap_sel_s)
        CAP_DATA: begin cap_int_r <= data[7:3];        cap_frac_r <= data[2:0]; end
        CAP_PEND: begin cap_int_r <= pend_data_r[7:3]; cap_frac_r <= pend_data_r[2:0]; end
        default:  begin cap_int_r <= cap_int_r;        cap_frac_r <= cap_frac_r; end
      endcase
      if (pend_wr_s) begin
        pend_data_r <= data;
        pend_r      <= 1'b1;
      end else if (pend_clr_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Segment patterns for the freshly converted sample
  always_comb begin
    if (BLANK_LEADING && (bcd_tens_s == 4'd0)) tens_seg_s = SEG_BLANK;
    else                                       tens_seg_s = {1'b1, seg7_hex(bcd_tens_s)};
    units_seg_s  = {1'b0, seg7_hex(bcd_units_s)};
    tenths_seg_s = {1'b1, seg7_hex(tenths_lut(cap_frac_r))};
  end

  // Shown digit registers, dashes until the first sample lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_tens_r   <= SEG_DASH;
      shown_units_r  <= SEG_DASH;
      shown_tenths_r <= SEG_DASH;
    end else if (load_shown_s) begin
      shown_tens_r   <= tens_seg_s;
      shown_units_r  <= units_seg_s;
      shown_tenths_r <= tenths_seg_s;
    end
  end

  // Scan counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      dig_idx_r  <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      dig_idx_r  <= dig_idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit slot selection
  always_comb begin
    slot_seg_s = SEG_BLANK;
    slot_dig_s = 4'hF;
    case (dig_idx_r)
      2'd0:    begin slot_seg_s = shown_tenths_r; slot_dig_s = 4'b1110; end
      2'd1:    begin slot_seg_s = shown_units_r;  slot_dig_s = 4'b1101; end
      2'd2:    begin slot_seg_s = shown_tens_r;   slot_dig_s = 4'b1011; end
      2'd3:    begin slot_seg_s = SEG_BLANK;      slot_dig_s = 4'b0111; end
      default: begin slot_seg_s = SEG_BLANK;      slot_dig_s = 4'hF;    end
    endcase
  end

  // seg and dig load together at the start of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      dig_r <= 4'hF;
    end else if (scan_cnt_r == '0) begin
      seg_r <= slot_seg_s;
      dig_r <= slot_dig_s;
    end
  end

  assign seg   = seg_r;
  assign dig   = dig_r;
  assign valid = valid_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_temp_display.sv
// Self-checking bench for temp_display: two instances (leading blank on/off) share
// stimulus; displayed digits are compared with a decimal model of the sample.
module tb_temp_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       update = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] seg_a, seg_b;
  logic [3:0] dig_a, dig_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  temp_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(data), .update(update),
    .seg(seg_a), .dig(dig_a), .valid(valid_a), .busy(busy_a)
  );

  temp_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(data), .update(update),
    .seg(seg_b), .dig(dig_b), .valid(valid_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pattern of digit position pos (0 = tenths) for sample d
  function automatic logic [7:0] model_seg(input logic [7:0] d, input bit have,
                                           input bit blank_lead, input int pos);
    int deg, tenth;
    deg   = int'(d[7:3]);
    tenth = (int'(d[2:0]) * 10) / 8;
    if (pos == 3) return 8'hFF;
    if (!have) return 8'hBF;
    case (pos)
      2:       if ((deg / 10 == 0) && blank_lead) return 8'hFF;
               else return {1'b1, seg_tbl[deg / 10]};
      1:       return {1'b0, seg_tbl[deg % 10]};
      default: return {1'b1, seg_tbl[tenth]};
    endcase
  endfunction

  task automatic scan_check(input string tag, input logic [7:0] d, input bit have);
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    int bad = 0;
    for (int p = 0; p < 4; p++) begin sa[p] = 8'h00; sb[p] = 8'h00; end
    repeat (20) begin
      @(negedge clk);
      case (dig_a)
        4'b1110: sa[0] = seg_a;
        4'b1101: sa[1] = seg_a;
        4'b1011: sa[2] = seg_a;
        4'b0111: sa[3] = seg_a;
        default: bad++;
      endcase
      case (dig_b)
        4'b1110: sb[0] = seg_b;
        4'b1101: sb[1] = seg_b;
        4'b1011: sb[2] = seg_b;
        4'b0111: sb[3] = seg_b;
        default: bad++;
      endcase
    end
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s blank1 dig%0d", tag, p), 32'(sa[p]), 32'(model_seg(d, have, 1'b1, p)));
      check($sformatf("%s blank0 dig%0d", tag, p), 32'(sb[p]), 32'(model_seg(d, have, 1'b0, p)));
    end
    check({tag, " onehot"}, 32'(bad), 32'd0);
    check({tag, " valid"}, 32'({valid_a, valid_b}), have ? 32'd3 : 32'd0);
  endtask

  task automatic pulse(input logic [7:0] d, input int hold);
    @(negedge clk);
    data   = d;
    update = 1'b1;
    repeat (hold) @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy_a || busy_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle bound"}, 32'(k < 200), 32'd1);
  endtask

  initial begin
    logic [3:0]  prev;
    logic [7:0]  d, last;
    int          run, bcount, first_valid, n_edges;

    // Reset and idle scan of dashes
    #1 rst_n = 1'b0;
    #3;
    check("rst seg", 32'(seg_a), 32'hFF);
    check("rst dig", 32'(dig_a), 32'hF);
    check("rst flags", 32'({valid_a, busy_a, valid_b, busy_b}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev = 4'hF;
    run  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_a) check("t1 valid low", 32'(valid_a), 32'd0);
      if (dig_a == prev) begin
        run++;
      end else begin
        if (prev == 4'hF) check("t1 first slot", 32'(dig_a), 32'b1110);
        else begin
          check("t1 slot length", 32'(run), 32'd4);
          check("t1 slot order", 32'(dig_a), 32'({prev[2:0], prev[3]}));
        end
        run  = 1;
        prev = dig_a;
      end
    end
    check("t1 valid", 32'(valid_a), 32'd0);
    scan_check("t1 dashes", 8'h00, 1'b0);

    // 25.5 with a long update level: one conversion, 7-cycle latency
    @(negedge clk);
    data = 8'b11001_100;
    update = 1'b1;
    bcount = 0;
    first_valid = -1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (busy_a) bcount++;
      if (valid_a && first_valid < 0) first_valid = k;
      if (k == 99) update = 1'b0;
    end
    check("t2 latency", 32'(first_valid), 32'd7);
    check("t2 busy cycles", 32'(bcount), 32'd7);
    scan_check("t2 25.5", 8'b11001_100, 1'b1);

    // Boundary values
    pulse(8'h00, 5);
    wait_idle("t3 zero");
    repeat (20) @(negedge clk);
    scan_check("t3 0.0", 8'h00, 1'b1);
    pulse(8'hFF, 5);
    wait_idle("t3 max");
    repeat (20) @(negedge clk);
    scan_check("t3 31.8", 8'hFF, 1'b1);

    // Three edges in flight: newest wins, two conversions back to back
    @(negedge clk);
    data = 8'h50;
    update = 1'b1;
    bcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_a) bcount++;
      case (k)
        0:       update = 1'b0;
        1:       begin data = 8'h98; update = 1'b1; end
        2:       update = 1'b0;
        3:       begin data = 8'hA0; update = 1'b1; end
        4:       update = 1'b0;
        default: ;
      endcase
    end
    check("t4 busy span", 32'(bcount), 32'd14);
    scan_check("t4 20.0", 8'hA0, 1'b1);

    // Async reset during conversion
    pulse(8'h77, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 seg", 32'({seg_a, seg_b}), 32'hFFFF);
    check("t5 dig", 32'({dig_a, dig_b}), 32'hFF);
    check("t5 flags", 32'({valid_a, busy_a, valid_b, busy_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    scan_check("t5 dashes", 8'h00, 1'b0);

    // Single-digit value, leading zero handling differs between instances
    pulse(8'h28, 3);
    wait_idle("t6");
    repeat (20) @(negedge clk);
    scan_check("t6 5.0", 8'h28, 1'b1);

    // Random single samples
    for (int i = 0; i < 15; i++) begin
      d = 8'($urandom_range(0, 255));
      pulse(d, $urandom_range(1, 30));
      wait_idle($sformatf("rnd%0d", i));
      repeat (20) @(negedge clk);
      scan_check($sformatf("rnd%0d", i), d, 1'b1);
    end

    // Random bursts of closely spaced edges
    for (int i = 0; i < 5; i++) begin
      n_edges = $urandom_range(2, 4);
      last = 8'h00;
      for (int e = 0; e < n_edges; e++) begin
        last = 8'($urandom_range(0, 255));
        pulse(last, 1);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle($sformatf("burst%0d", i));
      repeat (20) @(negedge clk);
      scan_check($sformatf("burst%0d", i), last, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
